// File: rtl/param_register_bank.sv
// Parametrised register bank: per-register functional ops with optional saturation,
// two read ports (combinational or write-through registered), sticky write mask and wrap pulse.
module param_register_bank #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned SEL_WIDTH  = 3,
    parameter int unsigned OUT_REG    = 0,
    parameter int unsigned SATURATE   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [NUM_REGS-1:0]   reg_sel_i,
    input  logic [2:0]            fun_sel_i,
    input  logic [SEL_WIDTH-1:0]  out_a_sel_i,
    input  logic [SEL_WIDTH-1:0]  out_b_sel_i,
    output logic [DATA_WIDTH-1:0] out_a_o,
    output logic [DATA_WIDTH-1:0] out_b_o,
    output logic [NUM_REGS-1:0]   valid_mask_o,
    output logic                  wrap_pulse_o
);

    localparam logic [DATA_WIDTH-1:0] AllOnes = '1;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   wrap_hit;
    logic [NUM_REGS-1:0]   mask_q, mask_d;
    logic                  wrap_q, wrap_d;
    logic [DATA_WIDTH-1:0] rd_a, rd_b;

    // RegSel is MSB-first: bit NUM_REGS-1-k enables register k.
    always_comb begin
        wrap_hit = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_d[k] = regs_q[k];
            if (reg_sel_i[NUM_REGS-1-k]) begin
                unique case (fun_sel_i)
                    3'b000: begin
                        if (regs_q[k] == '0) begin
                            wrap_hit[k] = 1'b1;
                            regs_d[k]   = (SATURATE != 0) ? '0 : AllOnes;
                        end else begin
                            regs_d[k] = regs_q[k] - DATA_WIDTH'(1);
                        end
                    end
                    3'b001: begin
                        if (regs_q[k] == AllOnes) begin
                            wrap_hit[k] = 1'b1;
                            regs_d[k]   = (SATURATE != 0) ? AllOnes : '0;
                        end else begin
                            regs_d[k] = regs_q[k] + DATA_WIDTH'(1);
                        end
                    end
                    3'b010: regs_d[k] = data_i;
                    3'b011: regs_d[k] = '0;
                    3'b100: regs_d[k] = DATA_WIDTH'(data_i[7:0]);
                    3'b101: regs_d[k] = DATA_WIDTH'(data_i[15:0]);
                    3'b110: regs_d[k] = {regs_q[k][DATA_WIDTH-9:0], data_i[7:0]};
                    3'b111: regs_d[k] = DATA_WIDTH'($signed(data_i[15:0]));
                endcase
            end
        end
    end

    always_comb begin
        mask_d = mask_q | reg_sel_i;
        wrap_d = |wrap_hit;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
            mask_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
            mask_q <= mask_d;
            wrap_q <= wrap_d;
        end
    end

    // Registered ports sample next-state values so a write shows up right after its edge.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (out_a_sel_i == SEL_WIDTH'(k)) begin
                rd_a = (OUT_REG != 0) ? regs_d[k] : regs_q[k];
            end
            if (out_b_sel_i == SEL_WIDTH'(k)) begin
                rd_b = (OUT_REG != 0) ? regs_d[k] : regs_q[k];
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] out_a_q, out_b_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                out_a_q <= '0;
                out_b_q <= '0;
            end else begin
                out_a_q <= rd_a;
                out_b_q <= rd_b;
            end
        end

        assign out_a_o = out_a_q;
        assign out_b_o = out_b_q;
    end else begin : g_out_comb
        assign out_a_o = rd_a;
        assign out_b_o = rd_b;
    end

    assign valid_mask_o = mask_q;
    assign wrap_pulse_o = wrap_q;

endmodule

// File: tb/tb_param_register_bank.sv
// Scoreboard bench: three bank configurations share one stimulus stream and are checked
// against an arithmetic reference model through an expected-response queue.
module tb_param_register_bank;

    localparam int CW   [3] = '{32, 32, 16};
    localparam int CN   [3] = '{8, 8, 4};
    localparam int COR  [3] = '{0, 1, 1};
    localparam int CSAT [3] = '{0, 1, 0};

    typedef struct packed {
        logic [2:0][31:0] a;
        logic [2:0][31:0] b;
        logic [2:0][15:0] m;
        logic [2:0]       w;
        int               id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] d   = '0;
    logic [2:0]  f   = '0;
    logic [15:0] en  = '0;
    logic [7:0]  rs0, rs1;
    logic [3:0]  rs2;
    int          sa [3] = '{0, 0, 0};
    int          sb [3] = '{0, 0, 0};
    int          nsa [3] = '{0, 0, 0};
    int          nsb [3] = '{0, 0, 0};
    logic [2:0]  sa0, sb0;
    logic [3:0]  sa1, sb1;
    logic [1:0]  sa2, sb2;
    logic [31:0] oa0, ob0, oa1, ob1;
    logic [15:0] oa2, ob2;
    logic [7:0]  vm0, vm1;
    logic [3:0]  vm2;
    logic        w0, w1, w2;

    logic [31:0] mr  [3][16];
    logic [15:0] mm  [3];
    bit          mw  [3];
    logic [31:0] moa [3];
    logic [31:0] mob [3];

    exp_t q[$];
    event mid_ev;
    int   nvec  = 0;
    int   nfail = 0;
    int   next_id = 0;

    always #5 clk = ~clk;

    always_comb begin
        rs0 = '0;
        rs1 = '0;
        rs2 = '0;
        for (int k = 0; k < 8; k++) begin
            rs0[7-k] = en[k];
            rs1[7-k] = en[k];
        end
        for (int k = 0; k < 4; k++) begin
            rs2[3-k] = en[k];
        end
    end

    assign sa0 = sa[0][2:0];
    assign sb0 = sb[0][2:0];
    assign sa1 = sa[1][3:0];
    assign sb1 = sb[1][3:0];
    assign sa2 = sa[2][1:0];
    assign sb2 = sb[2][1:0];

    param_register_bank #(.DATA_WIDTH(32), .NUM_REGS(8), .SEL_WIDTH(3), .OUT_REG(0),
                          .SATURATE(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .data_i(d), .reg_sel_i(rs0), .fun_sel_i(f),
        .out_a_sel_i(sa0), .out_b_sel_i(sb0), .out_a_o(oa0), .out_b_o(ob0),
        .valid_mask_o(vm0), .wrap_pulse_o(w0)
    );

    param_register_bank #(.DATA_WIDTH(32), .NUM_REGS(8), .SEL_WIDTH(4), .OUT_REG(1),
                          .SATURATE(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .data_i(d), .reg_sel_i(rs1), .fun_sel_i(f),
        .out_a_sel_i(sa1), .out_b_sel_i(sb1), .out_a_o(oa1), .out_b_o(ob1),
        .valid_mask_o(vm1), .wrap_pulse_o(w1)
    );

    param_register_bank #(.DATA_WIDTH(16), .NUM_REGS(4), .SEL_WIDTH(2), .OUT_REG(1),
                          .SATURATE(0)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .data_i(d[15:0]), .reg_sel_i(rs2), .fun_sel_i(f),
        .out_a_sel_i(sa2), .out_b_sel_i(sb2), .out_a_o(oa2), .out_b_o(ob2),
        .valid_mask_o(vm2), .wrap_pulse_o(w2)
    );

    // Reference operation on an unsigned value of CW[c] bits.
    function automatic logic [31:0] model_op(input int c, input logic [31:0] r,
                                             input logic [2:0] fs, input logic [31:0] dv,
                                             output bit wr);
        longint unsigned mx, rv, dd, res;
        mx  = (64'd1 << CW[c]) - 1;
        rv  = 64'(r);
        dd  = 64'(dv) & mx;
        wr  = 1'b0;
        res = 0;
        case (fs)
            3'd0: if (rv == 0) begin wr = 1'b1; res = (CSAT[c] != 0) ? 0 : mx; end
                  else res = rv - 1;
            3'd1: if (rv == mx) begin wr = 1'b1; res = (CSAT[c] != 0) ? mx : 0; end
                  else res = rv + 1;
            3'd2: res = dd;
            3'd3: res = 0;
            3'd4: res = dd % 256;
            3'd5: res = dd % 65536;
            3'd6: res = (rv * 256 + dd % 256) % (mx + 1);
            default: res = ((dd / 32768) % 2 == 1) ? (mx - 65535 + dd % 65536) : dd % 65536;
        endcase
        return 32'(res);
    endfunction

    function automatic logic [31:0] rd(input int c, input int s);
        return (s < CN[c]) ? mr[c][s] : 32'h0;
    endfunction

    function automatic logic [15:0] ord(input int c);
        logic [15:0] res = '0;
        for (int k = 0; k < CN[c]; k++) res[CN[c]-1-k] = mm[c][k];
        return res;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 16; k++) mr[c][k] = '0;
            mm[c] = '0; mw[c] = 1'b0; moa[c] = '0; mob[c] = '0;
        end
    endtask

    task automatic model_edge();
        bit wr, anyw;
        for (int c = 0; c < 3; c++) begin
            anyw = 1'b0;
            for (int k = 0; k < CN[c]; k++) begin
                if (en[k]) begin
                    mr[c][k] = model_op(c, mr[c][k], f, d, wr);
                    anyw = anyw | wr;
                    mm[c][k] = 1'b1;
                end
            end
            mw[c]  = anyw;
            moa[c] = rd(c, sa[c]);
            mob[c] = rd(c, sb[c]);
        end
    endtask

    task automatic push_exp(input bit mid);
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            e.a[c] = (mid && COR[c] == 0) ? rd(c, sa[c]) : moa[c];
            e.b[c] = (mid && COR[c] == 0) ? rd(c, sb[c]) : mob[c];
            e.m[c] = ord(c);
            e.w[c] = mw[c];
        end
        e.id = next_id;
        next_id++;
        q.push_back(e);
    endtask

    task automatic apply_sel();
        for (int c = 0; c < 3; c++) begin
            sa[c] = nsa[c];
            sb[c] = nsb[c];
        end
    endtask

    task automatic step(input logic [15:0] e_en, input logic [2:0] e_f,
                        input logic [31:0] e_d, input bit mid);
        @(negedge clk);
        en = e_en; f = e_f; d = e_d;
        apply_sel();
        if (mid) begin
            #1;
            push_exp(1'b1);
            ->mid_ev;
            #2;
        end
        model_edge();
        push_exp(1'b0);
    endtask

    // Asynchronous reset pulse between edges, checked while asserted, then a no-op edge.
    task automatic reset_pulse();
        @(negedge clk);
        en = '0;
        apply_sel();
        #1 rst = 1'b1;
        #1;
        model_reset();
        push_exp(1'b1);
        ->mid_ev;
        #2 rst = 1'b0;
        model_edge();
        push_exp(1'b0);
    endtask

    task automatic chk(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s vec=%0d got=%h want=%h", name, id, act, exp);
        end
    endtask

    always @(posedge clk or mid_ev) begin : monitor
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("outa0", e.id, oa0, e.a[0]);
            chk("outb0", e.id, ob0, e.b[0]);
            chk("mask0", e.id, 32'(vm0), 32'(e.m[0]));
            chk("wrap0", e.id, 32'(w0), 32'(e.w[0]));
            chk("outa1", e.id, oa1, e.a[1]);
            chk("outb1", e.id, ob1, e.b[1]);
            chk("mask1", e.id, 32'(vm1), 32'(e.m[1]));
            chk("wrap1", e.id, 32'(w1), 32'(e.w[1]));
            chk("outa2", e.id, 32'(oa2), e.a[2]);
            chk("outb2", e.id, 32'(ob2), e.b[2]);
            chk("mask2", e.id, 32'(vm2), 32'(e.m[2]));
            chk("wrap2", e.id, 32'(w2), 32'(e.w[2]));
        end
    end

    task automatic set_sel(input int a0, input int a1, input int a2,
                           input int b0, input int b1, input int b2);
        nsa[0] = a0; nsa[1] = a1; nsa[2] = a2;
        nsb[0] = b0; nsb[1] = b1; nsb[2] = b2;
    endtask

    initial begin
        model_reset();
        reset_pulse();

        // Reset landing in the middle of a write sequence.
        set_sel(0, 0, 0, 1, 1, 1);
        step(16'h0001, 3'b010, 32'h1234_5678, 1'b0);
        reset_pulse();
        step(16'h0000, 3'b010, 32'hFFFF_FFFF, 1'b0);

        // Functional ops on register 0.
        step(16'h0001, 3'b010, 32'h0000_80AB, 1'b0);
        step(16'h0001, 3'b110, 32'h0000_00CD, 1'b0);
        step(16'h0001, 3'b111, 32'h0000_8001, 1'b0);
        step(16'h0001, 3'b100, 32'h0000_01FF, 1'b0);
        step(16'h0001, 3'b101, 32'hDEAD_BEEF, 1'b0);
        step(16'h0001, 3'b111, 32'h1234_7FFF, 1'b0);
        step(16'h0001, 3'b011, 32'h5555_5555, 1'b0);

        // Increment/decrement at the boundaries of register 3.
        set_sel(3, 3, 3, 0, 0, 0);
        step(16'h0008, 3'b010, 32'hFFFF_FFFF, 1'b0);
        step(16'h0008, 3'b001, 32'h0, 1'b0);
        step(16'h0000, 3'b001, 32'h0, 1'b0);
        step(16'h0008, 3'b011, 32'h0, 1'b0);
        step(16'h0008, 3'b000, 32'h0, 1'b0);
        step(16'h0000, 3'b000, 32'h0, 1'b0);
        step(16'h0008, 3'b001, 32'h0, 1'b0);

        // Multi-hot increment of registers 1 and 2.
        set_sel(1, 1, 1, 2, 2, 2);
        step(16'h0002, 3'b010, 32'd5, 1'b0);
        step(16'h0004, 3'b010, 32'd9, 1'b0);
        step(16'h0006, 3'b001, 32'h0, 1'b0);

        // Read ports: write-through, delayed select change, out-of-range select.
        set_sel(4, 4, 0, 0, 0, 0);
        step(16'h0010, 3'b010, 32'h0000_00A5, 1'b0);
        set_sel(2, 2, 2, 0, 0, 0);
        step(16'h0000, 3'b000, 32'h0, 1'b1);
        set_sel(2, 2, 2, 7, 8, 3);
        step(16'h0000, 3'b000, 32'h0, 1'b1);
        set_sel(2, 2, 2, 7, 15, 3);
        step(16'h0000, 3'b000, 32'h0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] rd_v;
            set_sel($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 3),
                    $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) begin
                reset_pulse();
            end else begin
                rd_v = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                step(($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(0, 255)),
                     3'($urandom_range(0, 7)), rd_v, $urandom_range(0, 5) == 0);
            end
        end

        @(posedge clk);
        #3;
        nvec++;
        if (q.size() != 0) begin
            nfail++;
            $display("FAIL queue_drain got=%0d want=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/param_register_bank.md
Name: param_register_bank

Overview:
Parametrised general-purpose/scratch register bank for the datapath. It replaces the fixed 8x32 file with configurable width and depth. Each register supports per-cycle functional operations (inc/dec/load/clear/partial load/shift-load/sign-extend) with optional saturation. It has two read ports, optionally registered, plus status outputs: a written-register mask and an arithmetic wrap pulse.

Parameters:
DATA_WIDTH, 32, register width in bits; legal range is 16 or more.
NUM_REGS, 8, number of registers; legal range is 2 to 16.
SEL_WIDTH, 3, read-select width; must be at least clog2(NUM_REGS).
OUT_REG, 0, 0 gives combinational read ports; 1 gives registered read ports.
SATURATE, 0, 0 makes inc/dec wrap; 1 makes inc/dec saturate.

Ports:
Clock  input  1  rising-edge clock for all state
Reset  input  1  asynchronous, active-high; clears all state
I  input  DATA_WIDTH  write data, shared by all registers
RegSel  input  NUM_REGS  one-hot/multi-hot enable; MSB = register 0, LSB = register NUM_REGS-1
FunSel  input  3  operation applied to every enabled register
OutASel  input  SEL_WIDTH  read port A select
OutBSel  input  SEL_WIDTH  read port B select
OutA  output  DATA_WIDTH  read port A data
OutB  output  DATA_WIDTH  read port B data
ValidMask  output  NUM_REGS  sticky bit per register, set after any operation on it; same bit order as RegSel
WrapPulse  output  1  one-cycle pulse flagging an inc/dec boundary crossing

Behaviour:
- Reset asserted, at any time including mid-operation:
  - all registers go to 0 immediately;
  - ValidMask, WrapPulse, and the registered OutA/OutB (OUT_REG=1) go to 0;
  - FunSel/RegSel activity is ignored while Reset is high.
- On each rising Clock edge, each register whose RegSel bit is 1 updates as follows (R = current value, W = DATA_WIDTH):
  - 000: R-1
  - 001: R+1
  - 010: I
  - 011: 0
  - 100: zero-extend I[7:0]
  - 101: zero-extend I[15:0]
  - 110: (R << 8) | I[7:0]; upper bits shift out
  - 111: sign-extend I[15:0] to W bits
- Registers whose RegSel bit is 0 hold their value. RegSel = 0 is a no-op.
- Multiple enabled registers each apply the same FunSel to their own value independently.
- Wrap/saturation:
  - SATURATE=0: R=all-ones with 001 gives 0; R=0 with 000 gives all-ones.
  - SATURATE=1: the register holds all-ones or 0 respectively.
  - Either mode: WrapPulse=1 for exactly the cycle after any such edge (registered). Otherwise WrapPulse=0.
- ValidMask: bit is set on any edge where that register is enabled, including with FunSel=011. It is cleared only by Reset.
- Read, OUT_REG=0:
  - OutA = register[OutASel], purely combinational.
  - A written value appears after the write edge.
- Read, OUT_REG=1:
  - At each edge, OutA samples the next-state value of register[OutASel] (write-through).
  - A write at edge k is visible on OutA after edge k, as in OUT_REG=0.
  - A select change is visible one edge later.
- OutB is identical to OutA, using OutBSel.
- Select ≥ NUM_REGS returns 0 on that port.
- OutA and OutB may select the same register.
- No read/write hazard exists: reads never return a partially updated value.

Test Plan:
- Reset mid-write:
  - Stimulus: load R0=0x1234_5678 with RegSel MSB=1 and FunSel=010; on the next cycle, pulse Reset asynchronously between edges.
  - Response: OutA (sel 0) = 0 immediately; ValidMask = 0; the following edge with RegSel=0 keeps 0.
- Functional ops:
  - Stimulus: I=0x0000_80AB, FunSel 010, then 110 with I=0xCD, then 111 with I=0x8001, then 100 with I=0x1FF.
  - Response: register values 0x0000_80AB, 0x0080_ABCD, 0xFFFF_8001, 0x0000_00FF.
- Wrap and saturate, with R3=0xFFFF_FFFF:
  - Stimulus: FunSel 001.
  - Response for SATURATE=0: R3=0 and WrapPulse high for one cycle.
  - Response for SATURATE=1: R3 stays 0xFFFF_FFFF and WrapPulse high.
  - Stimulus: R3=0, FunSel 000.
  - Response: 0xFFFF_FFFF (wrap) or 0 (saturate), with WrapPulse.
- Multi-hot:
  - Stimulus: R1=5, R2=9, RegSel selecting R1 and R2, FunSel 001.
  - Response: R1=6, R2=10, others unchanged; ValidMask bits 1 and 2 set.
- Read ports, OUT_REG=1:
  - Stimulus: write R4=0xA5 while OutASel=4.
  - Response: OutA=0xA5 after the same edge.
  - Stimulus: switch OutASel to 2, then set OutBSel = NUM_REGS (out of range).
  - Response: OutA updates one edge later; OutB=0.
- Parameter sweep: DATA_WIDTH=16, NUM_REGS=4, SEL_WIDTH=2; repeat the functional-op and wrap scenarios with results truncated to 16 bits.
